// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: operand/tag widths, add/sub opcodes, and the
// reservation-station entry state and payload.
package tomasulo_pkg;

   localparam int DEPTH = 3;
   localparam int DW    = 8;
   localparam int TW    = 3;

   localparam logic [3:0] FUNC_ADD = 4'b0000;
   localparam logic [3:0] FUNC_SUB = 4'b0001;

   typedef enum logic [1:0] {
      FREE,
      WAIT,
      READY,
      EXEC
   } rs_state_e;

   typedef struct packed {
      logic [3:0]    func;
      logic [3:0]    rd;
      logic [TW-1:0] rob;
      logic [DW-1:0] s1_val;
      logic [TW-1:0] s1_tag;
      logic          s1_rdy;
      logic [DW-1:0] s2_val;
      logic [TW-1:0] s2_tag;
      logic          s2_rdy;
   } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: its FREE/WAIT/READY/EXEC lifecycle,
// operand capture at issue, and CDB snooping for pending operands.
module rs_entry
   import tomasulo_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          alloc_i,
   input  rs_entry_t     alloc_data_i,
   input  logic          cdb_valid_i,
   input  logic [TW-1:0] cdb_tag_i,
   input  logic [DW-1:0] cdb_data_i,
   input  logic          dispatch_i,
   input  logic          done_i,
   output rs_state_e     state_o,
   output rs_state_e     state_next_o,
   output logic [3:0]    func_o,
   output logic [3:0]    rd_o,
   output logic [TW-1:0] rob_o,
   output logic [DW-1:0] s1_val_o,
   output logic [DW-1:0] s2_val_o
);

   rs_state_e state_q, state_d;
   rs_entry_t data_q, data_d;
   logic      snoop;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      snoop   = 1'b0;
      case (state_q)
         FREE: begin
            if (alloc_i) begin
               data_d  = alloc_data_i;
               state_d = WAIT;
               snoop   = 1'b1;
            end
         end
         WAIT:  snoop = 1'b1;
         READY: if (dispatch_i) state_d = EXEC;
         EXEC:  if (done_i) state_d = FREE;
      endcase

      // A freshly issued entry snoops too, so a same-cycle broadcast is not lost.
      if (snoop && cdb_valid_i) begin
         if (!data_d.s1_rdy && (data_d.s1_tag == cdb_tag_i)) begin
            data_d.s1_val = cdb_data_i;
            data_d.s1_rdy = 1'b1;
         end
         if (!data_d.s2_rdy && (data_d.s2_tag == cdb_tag_i)) begin
            data_d.s2_val = cdb_data_i;
            data_d.s2_rdy = 1'b1;
         end
      end

      if ((state_d == WAIT) && data_d.s1_rdy && data_d.s2_rdy) begin
         state_d = READY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FREE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign state_o      = state_q;
   assign state_next_o = state_d;
   assign func_o       = data_q.func;
   assign rd_o         = data_q.rd;
   assign rob_o        = data_q.rob;
   assign s1_val_o     = data_q.s1_val;
   assign s2_val_o     = data_q.s2_val;

endmodule

// File: rtl/add_rs_dispatch.sv
// Three-entry add/sub reservation station: lowest-free issue, lowest-ready
// dispatch into a registered valid/ready payload, freed on exec completion.
module add_rs_dispatch
   import tomasulo_pkg::*;
(
   input  logic          clk1,
   input  logic          rst,
   input  logic          iss_valid,
   output logic          iss_ready,
   input  logic [3:0]    iss_func,
   input  logic [3:0]    iss_rd,
   input  logic [TW-1:0] iss_rob,
   input  logic          iss_s1_rdy,
   input  logic          iss_s2_rdy,
   input  logic [DW-1:0] iss_s1_val,
   input  logic [DW-1:0] iss_s2_val,
   input  logic [TW-1:0] iss_s1_tag,
   input  logic [TW-1:0] iss_s2_tag,
   input  logic          cdb_valid,
   input  logic [TW-1:0] cdb_tag,
   input  logic [DW-1:0] cdb_data,
   output logic          ex_b,
   input  logic          ex_ready,
   output logic [DW-1:0] rs1_data,
   output logic [DW-1:0] rs2_data,
   output logic [3:0]    func,
   output logic [3:0]    rd,
   output logic [TW-1:0] rob_ind,
   output logic [2:0]    rs_index,
   input  logic          ex_done,
   input  logic [2:0]    ex_done_idx,
   output logic [1:0]    occ
);

   rs_state_e        ent_state   [DEPTH];
   rs_state_e        ent_state_d [DEPTH];
   logic [3:0]       ent_func    [DEPTH];
   logic [3:0]       ent_rd      [DEPTH];
   logic [TW-1:0]    ent_rob     [DEPTH];
   logic [DW-1:0]    ent_s1      [DEPTH];
   logic [DW-1:0]    ent_s2      [DEPTH];
   logic [DEPTH-1:0] alloc, dispatch, done;
   logic             found_free, found_rdy, can_load;
   rs_entry_t        iss_entry;

   logic          ex_b_q, ex_b_d;
   logic [DW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic [3:0]    func_q, func_d, rd_q, rd_d;
   logic [TW-1:0] rob_q, rob_d;
   logic [2:0]    idx_q, idx_d;
   logic [1:0]    occ_q, occ_d;
   logic          iss_ready_q, iss_ready_d;

   always_comb begin
      iss_entry        = '0;
      iss_entry.func   = iss_func;
      iss_entry.rd     = iss_rd;
      iss_entry.rob    = iss_rob;
      iss_entry.s1_val = iss_s1_val;
      iss_entry.s1_tag = iss_s1_tag;
      iss_entry.s1_rdy = iss_s1_rdy;
      iss_entry.s2_val = iss_s2_val;
      iss_entry.s2_tag = iss_s2_tag;
      iss_entry.s2_rdy = iss_s2_rdy;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      rs_entry u_entry (
         .clk_i        (clk1),
         .rst_i        (rst),
         .alloc_i      (alloc[g]),
         .alloc_data_i (iss_entry),
         .cdb_valid_i  (cdb_valid),
         .cdb_tag_i    (cdb_tag),
         .cdb_data_i   (cdb_data),
         .dispatch_i   (dispatch[g]),
         .done_i       (done[g]),
         .state_o      (ent_state[g]),
         .state_next_o (ent_state_d[g]),
         .func_o       (ent_func[g]),
         .rd_o         (ent_rd[g]),
         .rob_o        (ent_rob[g]),
         .s1_val_o     (ent_s1[g]),
         .s2_val_o     (ent_s2[g])
      );
   end

   // The payload register may reload whenever it is empty or being consumed.
   always_comb begin
      alloc      = '0;
      dispatch   = '0;
      done       = '0;
      found_free = 1'b0;
      found_rdy  = 1'b0;
      can_load   = !ex_b_q || ex_ready;
      ex_b_d     = ex_b_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      func_d     = func_q;
      rd_d       = rd_q;
      rob_d      = rob_q;
      idx_d      = idx_q;
      if (ex_b_q && ex_ready) begin
         ex_b_d = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         done[i] = ex_done && (ex_done_idx == 3'(i));
         if (!found_free && (ent_state[i] == FREE)) begin
            found_free = 1'b1;
            alloc[i]   = iss_valid && iss_ready_q;
         end
         if (!found_rdy && can_load && (ent_state[i] == READY)) begin
            found_rdy   = 1'b1;
            dispatch[i] = 1'b1;
            ex_b_d      = 1'b1;
            rs1_d       = ent_s1[i];
            rs2_d       = ent_s2[i];
            func_d      = ent_func[i];
            rd_d        = ent_rd[i];
            rob_d       = ent_rob[i];
            idx_d       = 3'(i);
         end
      end
   end

   always_comb begin
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_state_d[i] != FREE) begin
            occ_d = occ_d + 2'd1;
         end
      end
      iss_ready_d = (occ_d != 2'(DEPTH));
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         ex_b_q      <= 1'b0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         func_q      <= FUNC_ADD;
         rd_q        <= '0;
         rob_q       <= '0;
         idx_q       <= '0;
         occ_q       <= '0;
         iss_ready_q <= 1'b1;
      end else begin
         ex_b_q      <= ex_b_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         func_q      <= func_d;
         rd_q        <= rd_d;
         rob_q       <= rob_d;
         idx_q       <= idx_d;
         occ_q       <= occ_d;
         iss_ready_q <= iss_ready_d;
      end
   end

   assign ex_b      = ex_b_q;
   assign rs1_data  = rs1_q;
   assign rs2_data  = rs2_q;
   assign func      = func_q;
   assign rd        = rd_q;
   assign rob_ind   = rob_q;
   assign rs_index  = idx_q;
   assign occ       = occ_q;
   assign iss_ready = iss_ready_q;

endmodule

// File: doc/add_rs_dispatch.md
Name: add_rs_dispatch

Overview:
- Three-entry reservation station for the add/sub functional unit. Accepts issued instructions and snoops the common data bus (CDB) to capture missing operands.
- Drives the add/sub execution unit's dispatch interface: ex_b, rs1_data, rs2_data, func, rob_ind, rd, rs_index.
- Frees an entry only when the execution unit reports completion for that rs_index. This is the initiator/producer side of the exec-unit dispatch protocol.

Parameters:
- DEPTH, 3, number of RS entries; also the legal range of rs_index.
- DW, 8, operand data width.
- TW, 3, ROB tag width; operand tags are ROB indices.

Ports:
- clk1  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  issue request.
- iss_ready  out  1  at least one entry FREE (registered).
- iss_func  in  4  0000 add, 0001 sub; other codes are carried through unchanged.
- iss_rd  in  4  destination architectural register.
- iss_rob  in  TW  destination ROB index.
- iss_s1_rdy / iss_s2_rdy  in  1 each  operand value valid.
- iss_s1_val / iss_s2_val  in  DW each  operand value (used when rdy=1).
- iss_s1_tag / iss_s2_tag  in  TW each  producing ROB index (used when rdy=0).
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TW  ROB index of the broadcast result.
- cdb_data  in  DW  broadcast value.
- ex_b  out  1  dispatch valid.
- ex_ready  in  1  exec unit can accept.
- rs1_data, rs2_data  out  DW each  operands.
- func  out  4  operation code.
- rd  out  4  destination register.
- rob_ind  out  TW  ROB index.
- rs_index  out  3  dispatched entry number.
- ex_done  in  1  exec completion pulse.
- ex_done_idx  in  3  entry being completed.
- occ  out  2  number of non-FREE entries.

Behaviour:
- Per-entry state: FREE -> WAIT (an operand pending) or READY -> EXEC -> FREE.
- Reset:
  - All entries FREE.
  - Outputs: ex_b=0, rs1_data=0, rs2_data=0, func=0, rd=0, rob_ind=0, rs_index=0, occ=0, iss_ready=1 on the first cycle after reset.
  - Reset mid-operation discards all entries and any pending dispatch; a later ex_done is ignored because its entry is FREE.
- Issue (iss_valid && iss_ready):
  - Writes the lowest-index FREE entry.
  - Next state is READY if both operands are ready, else WAIT.
- Issue + CDB in the same cycle: if cdb_valid and an issuing operand's tag == cdb_tag with rdy=0, the operand captures cdb_data and counts as ready (bypass).
- Wakeup: each cycle, every WAIT entry compares its pending tags with cdb_tag.
  - On a match it captures cdb_data and marks that operand ready.
  - The entry enters READY when both operands are ready.
  - Both operands may wake in the same cycle.
- Dispatch select:
  - When ex_b=0 or (ex_b && ex_ready), choose the lowest-index READY entry.
  - Register its payload onto the outputs, set ex_b=1, and move the entry to EXEC.
  - An entry reaching READY in cycle N is eligible for selection in N+1, not N.
- Handshake:
  - The transfer occurs on a cycle with ex_b && ex_ready.
  - While ex_b && !ex_ready, every payload output holds stable.
  - After a transfer with no other READY entry, ex_b drops to 0 next cycle; payload outputs then hold their last values.
  - Back-to-back dispatch is allowed: a new payload may load in the same cycle as a transfer.
- Latency: issue with both operands ready in cycle N -> ex_b=1 in cycle N+2 at the earliest (READY N+1, dispatched N+2).
- Completion:
  - ex_done with entry[ex_done_idx] in EXEC -> FREE next cycle.
  - ex_done naming a non-EXEC entry, or idx >= DEPTH, is ignored.
  - A freed entry is not reusable by an issue in the same cycle (iss_ready is registered).
- Full: iss_ready=0 when all DEPTH entries are non-FREE; iss_valid is ignored while iss_ready=0.
- occ: registered count of non-FREE entries, 0..3.
- Unknown func: dispatched unchanged; this block performs no functional check.

Decomposition:
- Shared package tomasulo_pkg holds:
  - FUNC_ADD=4'b0000, FUNC_SUB=4'b0001.
  - DW, TW.
  - Entry state enum {FREE, WAIT, READY, EXEC}.
  - The RS entry struct: func, rd, rob, s1/s2 value, tag, rdy.
- One sub-module is natural: rs_entry (one slot's state machine, operand capture and CDB compare), instantiated DEPTH times. Selection and the output register stay in add_rs_dispatch.

Test Plan:
- Issue add, s1=5 ready, s2=3 ready, rd=2, rob=1; ex_ready=1 -> ex_b=1 two cycles later with rs1=5, rs2=3, func=0000, rd=2, rob_ind=1, rs_index=0; occ=1 until ex_done idx=0, then 0.
- Issue sub with s2 pending tag=4; hold for 3 cycles (no dispatch); CDB tag=4 data=9 -> dispatch next+1 cycle with rs2=9.
- Same-cycle bypass: issue with s1 pending tag=2 while cdb_valid tag=2 data=7 -> entry READY next cycle, dispatched rs1=7.
- Fill 3 entries -> iss_ready=0; further iss_valid ignored; ex_done idx=1 -> iss_ready=1 next cycle; next issue lands in entry 1.
- Two entries READY, ex_ready=0 for 4 cycles -> payload of entry 0 held stable; ex_ready=1 -> entry 0 transfers, entry 2 payload appears the next cycle.
- Assert rst while one entry is in EXEC and ex_b=1 -> next cycle ex_b=0, occ=0, iss_ready=1; a following ex_done idx=0 has no effect.
